// File: rtl/key_reader_if.sv
// Purpose: captured-key event channel between key_reader and its consumer.
// Latency: none, wires only.
// Backpressure: key_valid/key_code stay put until the consumer pulses key_ack.
// Ports: key_valid, key_code and key_overflow flow producer -> consumer;
//        key_ack flows consumer -> producer.
interface key_reader_if;
    logic       key_valid;
    logic [2:0] key_code;
    logic       key_ack;
    logic       key_overflow;

    modport master (
        output key_valid,
        output key_code,
        output key_overflow,
        input  key_ack
    );

    modport slave (
        input  key_valid,
        input  key_code,
        input  key_overflow,
        output key_ack
    );
endinterface

// File: rtl/key_reader.sv
// Purpose: debounces NUM_KEYS active-low buttons and captures one press event at a time.
// Latency: a change sampled at edge N appears on key_level/key_press after edge N+DEBOUNCE_CYCLES+2;
//          key_valid follows one edge later.
// Backpressure: one pending event; a press that arrives while it is unacknowledged is dropped
//               and flagged on the sticky key_overflow.
// Ports: sys_clk_in/sys_rst_n (sync, active-low), key_n raw buttons,
//        key_level/key_press/key_release per key, evt = captured-event channel.
module key_reader #(
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int NUM_KEYS        = 8
) (
    input  logic                sys_clk_in,
    input  logic                sys_rst_n,
    input  logic [NUM_KEYS-1:0] key_n,
    output logic [NUM_KEYS-1:0] key_level,
    output logic [NUM_KEYS-1:0] key_press,
    output logic [NUM_KEYS-1:0] key_release,
    key_reader_if.master        evt
);

    localparam int             CW      = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0]  CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

    localparam logic [1:0] ST_RELEASED    = 2'd0;
    localparam logic [1:0] ST_PRESS_CHK   = 2'd1;
    localparam logic [1:0] ST_PRESSED     = 2'd2;
    localparam logic [1:0] ST_RELEASE_CHK = 2'd3;

    logic [NUM_KEYS-1:0] sync1_q, sync1_d;
    logic [NUM_KEYS-1:0] sync2_q, sync2_d;
    logic [1:0]          state_q [NUM_KEYS];
    logic [1:0]          state_d [NUM_KEYS];
    logic [CW-1:0]       cnt_q   [NUM_KEYS];
    logic [CW-1:0]       cnt_d   [NUM_KEYS];
    logic [NUM_KEYS-1:0] press_q, press_d;
    logic [NUM_KEYS-1:0] release_q, release_d;
    logic                valid_q, valid_d;
    logic [2:0]          code_q, code_d;
    logic                ovf_q, ovf_d;

    logic [2:0]          low_idx;
    logic                any_press;
    logic                multi_press;

    // Per-key synchronizer and debounce FSM.
    always_comb begin
        sync1_d   = key_n;
        sync2_d   = sync1_q;
        press_d   = '0;
        release_d = '0;
        for (int k = 0; k < NUM_KEYS; k++) begin
            state_d[k] = state_q[k];
            cnt_d[k]   = cnt_q[k];
            case (state_q[k])
                ST_RELEASED: begin
                    if (!sync2_q[k]) begin
                        state_d[k] = ST_PRESS_CHK;
                        cnt_d[k]   = '0;
                    end
                end
                ST_PRESS_CHK: begin
                    if (sync2_q[k]) begin
                        state_d[k] = ST_RELEASED;
                        cnt_d[k]   = '0;
                    end else if (cnt_q[k] == CNT_MAX) begin
                        state_d[k] = ST_PRESSED;
                        cnt_d[k]   = '0;
                        press_d[k] = 1'b1;
                    end else begin
                        cnt_d[k] = cnt_q[k] + CW'(1);
                    end
                end
                ST_PRESSED: begin
                    if (sync2_q[k]) begin
                        state_d[k] = ST_RELEASE_CHK;
                        cnt_d[k]   = '0;
                    end
                end
                default: begin // ST_RELEASE_CHK
                    if (!sync2_q[k]) begin
                        state_d[k] = ST_PRESSED;
                        cnt_d[k]   = '0;
                    end else if (cnt_q[k] == CNT_MAX) begin
                        state_d[k]   = ST_RELEASED;
                        cnt_d[k]     = '0;
                        release_d[k] = 1'b1;
                    end else begin
                        cnt_d[k] = cnt_q[k] + CW'(1);
                    end
                end
            endcase
        end
    end

    // Lowest pressed index wins; any additional set bit is a lost press.
    always_comb begin
        low_idx = '0;
        for (int i = NUM_KEYS - 1; i >= 0; i--) begin
            if (press_q[i]) begin
                low_idx = 3'(i);
            end
        end
        any_press   = |press_q;
        multi_press = |(press_q & (press_q - NUM_KEYS'(1)));
    end

    always_comb begin
        valid_d = valid_q;
        code_d  = code_q;
        ovf_d   = ovf_q;
        if (any_press) begin
            if (!valid_q || evt.key_ack) begin
                // Slot is free (or being freed this cycle): take the new event,
                // and the overflow history of the old one goes with the ack.
                valid_d = 1'b1;
                code_d  = low_idx;
                ovf_d   = multi_press;
            end else begin
                ovf_d = 1'b1;
            end
        end else if (evt.key_ack && valid_q) begin
            valid_d = 1'b0;
            ovf_d   = 1'b0;
        end
    end

    always_ff @(posedge sys_clk_in) begin
        if (!sys_rst_n) begin
            sync1_q   <= '1;
            sync2_q   <= '1;
            press_q   <= '0;
            release_q <= '0;
            valid_q   <= 1'b0;
            code_q    <= '0;
            ovf_q     <= 1'b0;
            for (int k = 0; k < NUM_KEYS; k++) begin
                state_q[k] <= ST_RELEASED;
                cnt_q[k]   <= '0;
            end
        end else begin
            sync1_q   <= sync1_d;
            sync2_q   <= sync2_d;
            press_q   <= press_d;
            release_q <= release_d;
            valid_q   <= valid_d;
            code_q    <= code_d;
            ovf_q     <= ovf_d;
            for (int k = 0; k < NUM_KEYS; k++) begin
                state_q[k] <= state_d[k];
                cnt_q[k]   <= cnt_d[k];
            end
        end
    end

    always_comb begin
        for (int k = 0; k < NUM_KEYS; k++) begin
            key_level[k] = (state_q[k] == ST_PRESSED) || (state_q[k] == ST_RELEASE_CHK);
        end
    end

    assign key_press        = press_q;
    assign key_release      = release_q;
    assign evt.key_valid    = valid_q;
    assign evt.key_code     = code_q;
    assign evt.key_overflow = ovf_q;

endmodule

// File: tb/tb_key_reader.sv
// Purpose: directed bench for key_reader with a press/release event scoreboard.
// Latency: pulses expected DEBOUNCE_CYCLES+2 edges after the first sampling edge.
// Backpressure: exercised through key_ack timing against pending events.
module tb_key_reader;

    localparam int DB = 4;
    localparam int NK = 8;

    typedef struct {
        logic [7:0] mask;
        int         cyc;
    } ev_t;

    logic          clk;
    logic          rst_n;
    logic [NK-1:0] key_n;
    logic [NK-1:0] key_level;
    logic [NK-1:0] key_press;
    logic [NK-1:0] key_release;

    key_reader_if kif ();

    key_reader #(.DEBOUNCE_CYCLES(DB), .NUM_KEYS(NK)) dut (
        .sys_clk_in  (clk),
        .sys_rst_n   (rst_n),
        .key_n       (key_n),
        .key_level   (key_level),
        .key_press   (key_press),
        .key_release (key_release),
        .evt         (kif)
    );

    int  total = 0;
    int  bad   = 0;
    int  cyc   = 0;
    bit  mon_en = 0;
    ev_t pq[$];
    ev_t rq[$];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc = cyc + 1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic push_press(input logic [7:0] m);
        ev_t e;
        e.mask = m;
        e.cyc  = cyc + DB + 3;
        pq.push_back(e);
    endtask

    task automatic push_release(input logic [7:0] m);
        ev_t e;
        e.mask = m;
        e.cyc  = cyc + DB + 3;
        rq.push_back(e);
    endtask

    // Scoreboard: every pulse must match the next expected event, mask and edge.
    always @(negedge clk) begin
        if (mon_en) begin
            if (key_press != '0) begin
                if (pq.size() == 0) begin
                    chk("press_unexpected", 32'(key_press), 32'h0);
                end else begin
                    ev_t e;
                    e = pq.pop_front();
                    chk("press_mask", 32'(key_press), 32'(e.mask));
                    chk("press_edge", 32'(cyc), 32'(e.cyc));
                end
            end
            if (key_release != '0) begin
                if (rq.size() == 0) begin
                    chk("release_unexpected", 32'(key_release), 32'h0);
                end else begin
                    ev_t e;
                    e = rq.pop_front();
                    chk("release_mask", 32'(key_release), 32'(e.mask));
                    chk("release_edge", 32'(cyc), 32'(e.cyc));
                end
            end
        end
    end

    initial begin
        rst_n       = 1'b0;
        key_n       = '1;
        kif.key_ack = 1'b0;
        tick(3);
        chk("rst_level",   32'(key_level),       32'h0);
        chk("rst_press",   32'(key_press),       32'h0);
        chk("rst_release", 32'(key_release),     32'h0);
        chk("rst_valid",   32'(kif.key_valid),   32'h0);
        chk("rst_code",    32'(kif.key_code),    32'h0);
        chk("rst_ovf",     32'(kif.key_overflow), 32'h0);
        rst_n  = 1'b1;
        mon_en = 1'b1;
        tick(2);

        // Single press of key 2, then ack and release.
        key_n[2] = 1'b0;
        push_press(8'h04);
        tick(7);
        chk("k2_level", 32'(key_level[2]), 32'h1);
        chk("k2_valid_late", 32'(kif.key_valid), 32'h0);
        tick(1);
        chk("k2_valid", 32'(kif.key_valid), 32'h1);
        chk("k2_code",  32'(kif.key_code),  32'h2);
        chk("k2_ovf",   32'(kif.key_overflow), 32'h0);
        kif.key_ack = 1'b1;
        tick(1);
        kif.key_ack = 1'b0;
        chk("k2_ack_valid", 32'(kif.key_valid), 32'h0);
        key_n[2] = 1'b1;
        push_release(8'h04);
        tick(8);
        chk("k2_rel_level", 32'(key_level[2]), 32'h0);

        // Bouncing key 0 never gets accepted.
        for (int r = 0; r < 5; r++) begin
            key_n[0] = 1'b0;
            tick(3);
            key_n[0] = 1'b1;
            tick(3);
        end
        tick(4);
        chk("bounce_level", 32'(key_level[0]), 32'h0);
        chk("bounce_valid", 32'(kif.key_valid), 32'h0);

        // Keys 5 and 3 together: lowest captured, other flagged.
        key_n[5] = 1'b0;
        key_n[3] = 1'b0;
        push_press(8'h28);
        tick(8);
        chk("dual_valid", 32'(kif.key_valid), 32'h1);
        chk("dual_code",  32'(kif.key_code),  32'h3);
        chk("dual_ovf",   32'(kif.key_overflow), 32'h1);
        kif.key_ack = 1'b1;
        tick(1);
        kif.key_ack = 1'b0;
        chk("dual_ack_valid", 32'(kif.key_valid), 32'h0);
        chk("dual_ack_ovf",   32'(kif.key_overflow), 32'h0);
        key_n[5] = 1'b1;
        key_n[3] = 1'b1;
        push_release(8'h28);
        tick(8);

        // Pending key 1; key 4 lost without ack; key 6 replaces with ack.
        key_n[1] = 1'b0;
        push_press(8'h02);
        tick(8);
        chk("k1_valid", 32'(kif.key_valid), 32'h1);
        chk("k1_code",  32'(kif.key_code),  32'h1);
        key_n[4] = 1'b0;
        push_press(8'h10);
        tick(8);
        chk("lost_code",  32'(kif.key_code),  32'h1);
        chk("lost_valid", 32'(kif.key_valid), 32'h1);
        chk("lost_ovf",   32'(kif.key_overflow), 32'h1);
        key_n[6] = 1'b0;
        push_press(8'h40);
        tick(7);
        kif.key_ack = 1'b1;
        tick(1);
        kif.key_ack = 1'b0;
        chk("swap_code",  32'(kif.key_code),  32'h6);
        chk("swap_valid", 32'(kif.key_valid), 32'h1);
        chk("swap_ovf",   32'(kif.key_overflow), 32'h0);
        kif.key_ack = 1'b1;
        tick(1);
        chk("clr_valid", 32'(kif.key_valid), 32'h0);
        tick(1);
        kif.key_ack = 1'b0;
        chk("idle_ack_valid", 32'(kif.key_valid), 32'h0);
        chk("idle_ack_ovf",   32'(kif.key_overflow), 32'h0);
        chk("idle_ack_code",  32'(kif.key_code),  32'h6);

        // Release key 4 alone: pulse 7 edges after release.
        key_n[4] = 1'b1;
        push_release(8'h10);
        tick(6);
        chk("k4_level_hold", 32'(key_level[4]), 32'h1);
        tick(1);
        chk("k4_level_rel", 32'(key_level[4]), 32'h0);
        tick(1);
        key_n[1] = 1'b1;
        key_n[6] = 1'b1;
        push_release(8'h42);
        tick(8);
        chk("k16_level", 32'(key_level), 32'h0);

        // Reset while key 7 is mid-debounce; it must re-debounce once.
        key_n[7] = 1'b0;
        tick(5);
        rst_n = 1'b0;
        tick(1);
        rst_n = 1'b1;
        chk("mid_rst_level", 32'(key_level),    32'h0);
        chk("mid_rst_press", 32'(key_press),    32'h0);
        chk("mid_rst_valid", 32'(kif.key_valid), 32'h0);
        chk("mid_rst_code",  32'(kif.key_code), 32'h0);
        chk("mid_rst_ovf",   32'(kif.key_overflow), 32'h0);
        push_press(8'h80);
        tick(8);
        chk("k7_valid", 32'(kif.key_valid), 32'h1);
        chk("k7_code",  32'(kif.key_code),  32'h7);
        chk("k7_level", 32'(key_level[7]),  32'h1);

        tick(10);
        chk("press_queue_drained",   32'(pq.size()), 32'h0);
        chk("release_queue_drained", 32'(rq.size()), 32'h0);
        mon_en = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/key_reader.md
KEY_READER -- requirements
Module: key_reader

Parameters
REQ-001 DEBOUNCE_CYCLES, default 500000, number of consecutive stable cycles required to accept a key change (legal range 2..2^24-1).
REQ-002 NUM_KEYS, default 8, number of push-button inputs (legal range 1..8).

Interface
REQ-003 sys_clk_in  input  1  single system clock; all state changes on its rising edge.
REQ-004 sys_rst_n  input  1  reset, synchronous and active-low.
REQ-005 key_n  input  NUM_KEYS  raw push buttons, active-low, asynchronous to sys_clk_in, bouncing.
REQ-006 key_level  output  NUM_KEYS  debounced level per key, 1 = pressed.
REQ-007 key_press  output  NUM_KEYS  one-cycle pulse per key on accepted press.
REQ-008 key_release  output  NUM_KEYS  one-cycle pulse per key on accepted release.
REQ-009 key_valid  output  1  a captured press event is pending.
REQ-010 key_code  output  3  index of captured key; stable while key_valid=1.
REQ-011 key_ack  input  1  consumer acknowledges pending event.
REQ-012 key_overflow  output  1  sticky: a press was lost while key_valid=1.

Function
REQ-013 Each key_n bit SHALL pass through a 2-flop synchronizer before any other logic; sync flops reset to 1 (released).
REQ-014 Each key SHALL have an independent FSM: RELEASED, PRESS_CHK, PRESSED, RELEASE_CHK, plus a counter wide enough for DEBOUNCE_CYCLES-1.
REQ-015 RELEASED: synced level low -> PRESS_CHK, counter=0; else stay.
REQ-016 PRESS_CHK: synced level high -> RELEASED (bounce, no pulse); counter==DEBOUNCE_CYCLES-1 -> PRESSED with key_press pulse; else counter+1.
REQ-017 PRESSED: synced level high -> RELEASE_CHK, counter=0; else stay.
REQ-018 RELEASE_CHK: synced level low -> PRESSED (bounce, no pulse); counter==DEBOUNCE_CYCLES-1 -> RELEASED with key_release pulse; else counter+1.
REQ-019 key_level SHALL be 1 exactly in PRESSED and RELEASE_CHK; key_press/key_release SHALL be registered, high one cycle, in the cycle following the transition edge.
REQ-020 Latency: key_n held low from rising edge N -> FSM enters PRESSED and key_press is high in the cycle after edge N+DEBOUNCE_CYCLES+2; release latency identical.
REQ-021 Capture: on any key_press bit with key_valid=0, latch key_code = lowest set index and set key_valid=1 on the next edge.
REQ-022 Simultaneous presses in one cycle: lowest index captured; higher indices discarded and key_overflow set.
REQ-023 key_press while key_valid=1 and key_ack=0: key_code unchanged, key_overflow set.
REQ-024 key_ack=1 with key_valid=1 and no press: key_valid cleared, key_overflow cleared on the next edge.
REQ-025 key_ack=1 and a press in the same cycle: new code latched, key_valid stays 1, key_overflow cleared.
REQ-026 key_ack while key_valid=0 SHALL be ignored.
REQ-027 Unused key_code upper bits (NUM_KEYS<8) SHALL follow the index value; inputs beyond NUM_KEYS do not exist.

Reset
REQ-028 With sys_rst_n low at a rising edge: all FSMs RELEASED, counters 0, sync flops 1, key_level/key_press/key_release=0, key_valid=0, key_code=0, key_overflow=0.
REQ-029 Reset mid-debounce or mid-press SHALL discard the pending transition; a key held low through reset is re-debounced from RELEASED after reset deasserts and produces one key_press.

Verification (DEBOUNCE_CYCLES=4, NUM_KEYS=8)
REQ-030 key_n[2] low from edge 10, held -> key_press[2] high only in cycle after edge 16, key_level[2]=1 from then, key_valid=1, key_code=2.
REQ-031 key_n[0] low 3 cycles then high (bounce), repeat 5x -> no key_press, key_level[0] stays 0, key_valid stays 0.
REQ-032 keys 5 and 3 low on same edge, held -> key_press=8'h28 one cycle, key_code=3, key_overflow=1; key_ack -> key_valid=0, key_overflow=0.
REQ-033 pending code 1, second press of key 6 arrives in cycle with key_ack=1 -> key_code=6, key_valid=1, key_overflow=0.
REQ-034 key 4 pressed and accepted, then released held -> key_release[4] one cycle 7 edges after release, key_level[4]=0.
REQ-035 sys_rst_n low for 1 edge while key 7 in PRESS_CHK with counter=2, key held -> all outputs 0 after reset; key_press[7] occurs 7 edges after reset release.
